foward_hazard_unit: RTL and testbench
=====================================

# foward_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined MIPS core. Generalises the two-operand, purely combinational forwarding unit to NUM_SRC source operands, configurable register-address width, and load results with extra latency. Adds a registered stall FSM with a cycle counter and a saturating stall-event counter. Sits beside the ID/EX stage and drives the EX operand muxes, the PC/IF-ID write enables and the ID/EX bubble insert.

## Interface
Parameters:
- REG_ADDR_W, 5: register address width.
- NUM_SRC, 2: number of source operands per instruction (3 when store data is forwarded separately).
- LOAD_LAT, 0: extra cycles, beyond the standard pipeline, before load data can be forwarded (0..7).
- PERF_W, 16: width of the stall-event counter.

Ports:
- i_clock  in  1  core clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_flush  in  1  branch/jump flush of IF/ID and ID/EX this cycle.
- i_id_ex_src  in  NUM_SRC*REG_ADDR_W  EX-stage source registers; operand k is at bits [k*REG_ADDR_W +: REG_ADDR_W].
- i_ex_mem_RegWrite  in  1  EX/MEM writes a register.
- i_ex_mem_rd  in  REG_ADDR_W  EX/MEM destination.
- i_mem_wb_RegWrite  in  1  MEM/WB writes a register.
- i_mem_wb_rd  in  REG_ADDR_W  MEM/WB destination.
- i_if_id_src  in  NUM_SRC*REG_ADDR_W  ID-stage source registers.
- i_if_id_src_valid  in  NUM_SRC  per-operand "actually read" mask.
- i_id_ex_MemRead  in  1  ID/EX instruction is a load.
- i_id_ex_rd  in  REG_ADDR_W  load destination.
- o_foward_sel  out  2*NUM_SRC  per-operand select; operand k is at bits [2k +: 2].
- o_stall  out  1  hold the PC and IF/ID.
- o_bubble  out  1  zero the ID/EX control signals.
- o_stall_count  out  PERF_W  number of load-use events, saturating.

## Operation
- Forward select encoding: 2'b00 = register file, 2'b10 = EX/MEM, 2'b01 = MEM/WB. 2'b11 is never driven.
- Per operand k:
  - Select 2'b10 if i_ex_mem_RegWrite, i_ex_mem_rd != 0 and i_ex_mem_rd == src[k].
  - Otherwise select 2'b01 if the same condition holds for MEM/WB.
  - Otherwise select 2'b00.
  - EX/MEM always wins over MEM/WB.
  - Register 0 is never forwarded.
  - All operands are evaluated independently; several operands may select the same stage.
- Load-use detect (combinational): i_id_ex_MemRead, i_id_ex_rd != 0, and for some k, i_if_id_src_valid[k] && i_if_id_src[k] == i_id_ex_rd.
- FSM states are IDLE and STALL, with a 3-bit down-counter cnt.
  - IDLE, detect, no flush:
    - o_stall = o_bubble = 1 this cycle.
    - o_stall_count increments by 1 (saturating).
    - If LOAD_LAT > 0, go to STALL with cnt = LOAD_LAT-1.
  - STALL:
    - o_stall = o_bubble = 1.
    - Detect is ignored.
    - When cnt == 0, go to IDLE; otherwise decrement cnt.
  - i_flush in any state: o_stall = o_bubble = 0, next state IDLE, cnt = 0, no count increment. Flush has priority over detect and over STALL.
- Total stall per load-use event is 1+LOAD_LAT cycles.
- o_foward_sel does not depend on FSM state.

## Timing
- o_foward_sel is purely combinational from its inputs, with zero latency.
- o_stall and o_bubble are combinational from detect, the state and i_flush. Their first stall cycle falls in the same cycle as detect.
- State, cnt and o_stall_count update on the rising edge of i_clock.
- Reset (i_reset low, asynchronous): state IDLE, cnt 0, o_stall_count 0.
  - While i_reset is low, o_stall = 0 and o_bubble = 0; detect is masked.
  - o_foward_sel still follows its inputs.
- Reset asserted mid-STALL aborts the stall immediately.
- o_stall_count holds at 2^PERF_W-1 once reached; it never wraps.
- Back-to-back loads: a new detect in the first IDLE cycle after STALL starts a new event.

## Structure
- Package foward_pkg holds:
  - FWD_NONE, FWD_EXMEM and FWD_MEMWB encodings.
  - State encodings ST_IDLE and ST_STALL.
  - The counter width constant CNT_W = 3.
- Sub-module foward_select: one operand's comparator and priority logic. It is instantiated NUM_SRC times via generate.
- The FSM, load-use compare and perf counter live in the top level.

## Test plan
- Forwarding priority: NUM_SRC=3, src={10,5,10}, ex_mem_rd=10/RegWrite=1, mem_wb_rd=5/RegWrite=1 -> sel = {10,01,10}. Repeat with ex_mem_rd=5 as well -> sel[1] = 10.
- Register 0: all src=0, both rd=0, both RegWrite=1 -> all sel = 00. RegWrite=0 with matching rd=7 -> sel = 00.
- Load-use, LOAD_LAT=0: id_ex_MemRead=1, id_ex_rd=8, if_id_src[0]=8, valid=1 -> stall/bubble high exactly 1 cycle; o_stall_count goes 0 to 1. The same match with valid[0]=0 -> no stall.
- LOAD_LAT=2: the same detect -> stall/bubble high exactly 3 consecutive cycles, then low. A detect repeated during STALL does not extend the stall or increment the count.
- Flush: i_flush=1 in the 2nd stall cycle with LOAD_LAT=2 -> stall low that cycle and IDLE next. i_flush together with detect -> no stall and no count increment.
- Reset and saturation:
  - i_reset low mid-STALL -> stall low immediately, counter cleared.
  - With PERF_W=2, after 5 events -> o_stall_count = 3.

Source files
------------

// File: rtl/foward_pkg.sv
// Shared encodings for the forwarding / load-use hazard unit: operand mux
// selects, stall FSM states and the stall down-counter width.
package foward_pkg;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int CNT_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

endpackage

// File: rtl/foward_select.sv
// Forwarding select for a single EX-stage source operand. The youngest
// producer (EX/MEM) beats MEM/WB, and register 0 is never forwarded.
module foward_select
    import foward_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_src,
    input  logic                  i_ex_mem_RegWrite,
    input  logic [REG_ADDR_W-1:0] i_ex_mem_rd,
    input  logic                  i_mem_wb_RegWrite,
    input  logic [REG_ADDR_W-1:0] i_mem_wb_rd,
    output logic [1:0]            o_sel
);

    logic exMemHit;
    logic memWbHit;

    assign exMemHit = i_ex_mem_RegWrite && (i_ex_mem_rd != '0) && (i_ex_mem_rd == i_src);
    assign memWbHit = i_mem_wb_RegWrite && (i_mem_wb_rd != '0) && (i_mem_wb_rd == i_src);

    always_comb begin
        o_sel = FWD_NONE;
        if (exMemHit) begin
            o_sel = FWD_EXMEM;
        end else if (memWbHit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/foward_hazard_unit.sv
// Operand forwarding plus load-use stall control for the pipelined MIPS core.
// Each load-use event stalls 1+LOAD_LAT cycles and bumps a saturating counter.
module foward_hazard_unit
    import foward_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned LOAD_LAT   = 0,
    parameter int unsigned PERF_W     = 16
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_flush,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]    i_id_ex_src,
    input  logic                             i_ex_mem_RegWrite,
    input  logic [REG_ADDR_W-1:0]            i_ex_mem_rd,
    input  logic                             i_mem_wb_RegWrite,
    input  logic [REG_ADDR_W-1:0]            i_mem_wb_rd,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]    i_if_id_src,
    input  logic [NUM_SRC-1:0]               i_if_id_src_valid,
    input  logic                             i_id_ex_MemRead,
    input  logic [REG_ADDR_W-1:0]            i_id_ex_rd,
    output logic [2*NUM_SRC-1:0]             o_foward_sel,
    output logic                             o_stall,
    output logic                             o_bubble,
    output logic [PERF_W-1:0]                o_stall_count
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'((LOAD_LAT > 0) ? LOAD_LAT - 1 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PERF_W-1:0] stallCount_q, stallCount_d;
    logic [NUM_SRC-1:0] useMatch;
    logic              loadUse;
    logic              stallNow;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_sel
        foward_select #(
            .REG_ADDR_W (REG_ADDR_W)
        ) u_foward_select (
            .i_src             (i_id_ex_src[k*REG_ADDR_W +: REG_ADDR_W]),
            .i_ex_mem_RegWrite (i_ex_mem_RegWrite),
            .i_ex_mem_rd       (i_ex_mem_rd),
            .i_mem_wb_RegWrite (i_mem_wb_RegWrite),
            .i_mem_wb_rd       (i_mem_wb_rd),
            .o_sel             (o_foward_sel[2*k +: 2])
        );
    end

    always_comb begin
        useMatch = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            useMatch[k] = i_if_id_src_valid[k] && (i_if_id_src[k*REG_ADDR_W +: REG_ADDR_W] == i_id_ex_rd);
        end
    end

    // Detect is masked during reset so the outputs stay quiet while held.
    assign loadUse  = i_reset && i_id_ex_MemRead && (i_id_ex_rd != '0) && (|useMatch);
    assign stallNow = i_reset && !i_flush && ((state_q == ST_STALL) || loadUse);
    assign o_stall  = stallNow;
    assign o_bubble = stallNow;
    assign o_stall_count = stallCount_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stallCount_d = stallCount_q;
        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (loadUse) begin
                        if (stallCount_q != '1) begin
                            stallCount_d = stallCount_q + PERF_W'(1);
                        end
                        if (LOAD_LAT > 0) begin
                            state_d = ST_STALL;
                            cnt_d   = LAT_INIT;
                        end
                    end
                end
                ST_STALL: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            stallCount_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stallCount_q <= stallCount_d;
        end
    end

endmodule

// File: tb/tb_foward_hazard_unit.sv
// Self-checking bench: two instances (LOAD_LAT=0/PERF_W=16 and LOAD_LAT=2/PERF_W=2)
// share stimulus and are compared against a stall-cycles-remaining reference model.
module tb_foward_hazard_unit;

    localparam int W  = 5;
    localparam int NS = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic [NS*W-1:0] idExSrc;
    logic          exMemRegWrite;
    logic [W-1:0]  exMemRd;
    logic          memWbRegWrite;
    logic [W-1:0]  memWbRd;
    logic [NS*W-1:0] ifIdSrc;
    logic [NS-1:0] ifIdSrcValid;
    logic          idExMemRead;
    logic [W-1:0]  idExRd;

    logic [2*NS-1:0] selA, selB;
    logic          stallA, bubbleA, stallB, bubbleB;
    logic [15:0]   countA;
    logic [1:0]    countB;

    int checks = 0;
    int errors = 0;

    int remA = 0, cntA = 0;
    int remB = 0, cntB = 0;

    always #5 clock = ~clock;

    foward_hazard_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .LOAD_LAT(0), .PERF_W(16)) dutA (
        .i_clock(clock), .i_reset(reset), .i_flush(flush),
        .i_id_ex_src(idExSrc), .i_ex_mem_RegWrite(exMemRegWrite), .i_ex_mem_rd(exMemRd),
        .i_mem_wb_RegWrite(memWbRegWrite), .i_mem_wb_rd(memWbRd),
        .i_if_id_src(ifIdSrc), .i_if_id_src_valid(ifIdSrcValid),
        .i_id_ex_MemRead(idExMemRead), .i_id_ex_rd(idExRd),
        .o_foward_sel(selA), .o_stall(stallA), .o_bubble(bubbleA), .o_stall_count(countA)
    );

    foward_hazard_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .LOAD_LAT(2), .PERF_W(2)) dutB (
        .i_clock(clock), .i_reset(reset), .i_flush(flush),
        .i_id_ex_src(idExSrc), .i_ex_mem_RegWrite(exMemRegWrite), .i_ex_mem_rd(exMemRd),
        .i_mem_wb_RegWrite(memWbRegWrite), .i_mem_wb_rd(memWbRd),
        .i_if_id_src(ifIdSrc), .i_if_id_src_valid(ifIdSrcValid),
        .i_id_ex_MemRead(idExMemRead), .i_id_ex_rd(idExRd),
        .o_foward_sel(selB), .o_stall(stallB), .o_bubble(bubbleB), .o_stall_count(countB)
    );

    // Reference forwarding: newest writer of a nonzero register wins.
    function automatic logic [2*NS-1:0] expSel();
        logic [2*NS-1:0] s;
        logic [W-1:0] src;
        s = '0;
        for (int k = 0; k < NS; k++) begin
            src = idExSrc[k*W +: W];
            if (exMemRegWrite && exMemRd != 0 && exMemRd == src) s[2*k +: 2] = 2'b10;
            else if (memWbRegWrite && memWbRd != 0 && memWbRd == src) s[2*k +: 2] = 2'b01;
        end
        return s;
    endfunction

    function automatic bit expDetect();
        bit hit;
        hit = 0;
        for (int k = 0; k < NS; k++) begin
            if (ifIdSrcValid[k] && ifIdSrc[k*W +: W] == idExRd) hit = 1;
        end
        return reset && idExMemRead && (idExRd != 0) && hit;
    endfunction

    function automatic bit expStall(int rem);
        return reset && !flush && (rem > 0 || expDetect());
    endfunction

    task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model advance: rem counts further stall cycles owed after this one.
    task automatic advanceModel(inout int rem, inout int cnt, input int lat, input int maxCnt, input bit det);
        if (!reset) begin
            rem = 0;
            cnt = 0;
        end else if (flush) begin
            rem = 0;
        end else if (rem > 0) begin
            rem = rem - 1;
        end else if (det) begin
            rem = lat;
            if (cnt < maxCnt) cnt = cnt + 1;
        end
    endtask

    task automatic applyStimulus(input logic fl, input logic [NS*W-1:0] exSrc,
                                 input logic exWr, input logic [W-1:0] exRd,
                                 input logic wbWr, input logic [W-1:0] wbRd,
                                 input logic [NS*W-1:0] idSrc, input logic [NS-1:0] valid,
                                 input logic memRd, input logic [W-1:0] ldRd);
        flush = fl;
        idExSrc = exSrc;
        exMemRegWrite = exWr;
        exMemRd = exRd;
        memWbRegWrite = wbWr;
        memWbRd = wbRd;
        ifIdSrc = idSrc;
        ifIdSrcValid = valid;
        idExMemRead = memRd;
        idExRd = ldRd;
    endtask

    // Compare all outputs mid-cycle, then clock the DUT and the model together.
    task automatic checkOutput();
        bit det;
        #2;
        checkVal("selA", 32'(selA), 32'(expSel()));
        checkVal("selB", 32'(selB), 32'(expSel()));
        checkVal("stallA", 32'(stallA), 32'(expStall(remA)));
        checkVal("bubbleA", 32'(bubbleA), 32'(expStall(remA)));
        checkVal("stallB", 32'(stallB), 32'(expStall(remB)));
        checkVal("bubbleB", 32'(bubbleB), 32'(expStall(remB)));
        checkVal("countA", 32'(countA), 32'(cntA));
        checkVal("countB", 32'(countB), 32'(cntB));
        @(posedge clock);
        det = expDetect();
        advanceModel(remA, cntA, 0, 65535, det);
        advanceModel(remB, cntB, 2, 3, det);
        #1;
    endtask

    task automatic loadUse(input logic fl, input logic valid0);
        applyStimulus(fl, '0, 0, 0, 0, 0, {10'd0, 5'd8}, {2'b00, valid0}, 1, 8);
    endtask

    task automatic idleInputs();
        applyStimulus(0, '0, 0, 0, 0, 0, '0, '0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        idleInputs();
        #1;
        checkOutput();
        checkVal("resetCountB", 32'(countB), 32'd0);
        reset = 1'b1;
        checkOutput();

        applyStimulus(0, {5'd10, 5'd5, 5'd10}, 1, 10, 1, 5, '0, '0, 0, 0);
        #2;
        checkVal("fwdPriority", 32'(selA), 32'b10_01_10);
        checkOutput();
        applyStimulus(0, {5'd10, 5'd5, 5'd10}, 1, 5, 1, 5, '0, '0, 0, 0);
        #2;
        checkVal("fwdExMemWins", 32'(selA[3:2]), 32'b10);
        checkOutput();
        applyStimulus(0, '0, 1, 0, 1, 0, '0, '0, 0, 0);
        checkOutput();
        applyStimulus(0, {5'd7, 5'd7, 5'd7}, 0, 7, 0, 7, '0, '0, 0, 0);
        #2;
        checkVal("fwdNoRegWrite", 32'(selA), 32'd0);
        checkOutput();

        loadUse(0, 1);
        #2;
        checkVal("loadUseStallA", 32'(stallA), 32'd1);
        checkOutput();
        idleInputs();
        #2;
        checkVal("lat0OneCycle", 32'(stallA), 32'd0);
        checkVal("countAfterOne", 32'(countA), 32'd1);
        checkOutput();
        repeat (3) checkOutput();
        loadUse(0, 0);
        repeat (2) checkOutput();

        loadUse(0, 1);
        repeat (3) checkOutput();
        checkVal("noExtendB", 32'(countB), 32'd2);
        idleInputs();
        repeat (3) checkOutput();

        loadUse(0, 1);
        checkOutput();
        flush = 1'b1;
        #2;
        checkVal("flushStall", 32'(stallB), 32'd0);
        checkOutput();
        idleInputs();
        repeat (2) checkOutput();
        loadUse(1, 1);
        repeat (2) checkOutput();
        idleInputs();
        checkOutput();

        loadUse(0, 1);
        checkOutput();
        reset = 1'b0;
        remA = 0; cntA = 0; remB = 0; cntB = 0;
        checkOutput();
        reset = 1'b1;
        idleInputs();
        checkOutput();

        for (int e = 0; e < 5; e++) begin
            loadUse(0, 1);
            checkOutput();
            idleInputs();
            repeat (2) checkOutput();
        end
        checkVal("saturateB", 32'(countB), 32'd3);

        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 9) == 0,
                          NS*W'($urandom), $urandom_range(0, 1) == 1, W'($urandom_range(0, 7)),
                          $urandom_range(0, 1) == 1, W'($urandom_range(0, 7)),
                          {W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), W'($urandom_range(0, 7))},
                          NS'($urandom), $urandom_range(0, 1) == 1, W'($urandom_range(0, 7)));
            idExSrc = {W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), W'($urandom_range(0, 7))};
            checkOutput();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
